laser_dac_spi_rx: RTL and testbench

//  Receive-side model of the dual 12-bit galvo DAC serial link (mosi/sclk/csn/latchn) driven by the laser beta's SPI port.

---
 rtl/laser_dac_spi_rx_pkg.sv | 20 ++
 rtl/laser_dac_rx_sync.sv | 30 +++
 rtl/laser_dac_spi_rx.sv | 200 ++++++++++++++++++++
 tb/tb_laser_dac_spi_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_dac_spi_rx_pkg.sv
// Shared definitions for the galvo DAC link receiver: command word field
// positions, FSM state encoding and the control-field reset value.
package laser_dac_spi_rx_pkg;

  // Command word layout: [15]=A_n/B, [14]=buf, [13]=ga_n, [12]=shdn_n, [11:0]=code.
  localparam int CMD_AB_BIT   = 15;
  localparam int CMD_BUF_BIT  = 14;
  localparam int CMD_GA_BIT   = 13;
  localparam int CMD_SHDN_BIT = 12;

  // {buf, ga_n, shdn_n}: unbuffered, gain 1x, shut down.
  localparam logic [2:0] CTRL_RESET = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

endpackage

// File: rtl/laser_dac_rx_sync.sv
// Multi-flop synchronizer for asynchronous link inputs, with a selectable
// value loaded on reset so idle lines come up in their inactive level.
module laser_dac_rx_sync #(
  parameter int               STAGES    = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the pin value through the synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true STAGES-deep pipeline.
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/laser_dac_spi_rx.sv
// Receive side of the dual 12-bit galvo DAC serial link. Oversamples
// mosi/sclk/csn/latchn, decodes 16-bit command words into per-channel input
// registers and transfers both channels to the outputs on latch.
// Optional feature macro: LASER_DAC_RX_RGB_EN (capture laser colour on latch).
module laser_dac_spi_rx
  import laser_dac_spi_rx_pkg::*;
#(
  parameter int WORD_BITS   = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dac_mosi,
  input  logic                 dac_sclk,
  input  logic                 dac_csn,
  input  logic                 dac_latchn,
  input  logic [2:0]           laser_rgb,
  output logic [DATA_BITS-1:0] dac_a,
  output logic [DATA_BITS-1:0] dac_b,
  output logic [2:0]           ctrl_a,
  output logic [2:0]           ctrl_b,
  output logic                 point_strobe,
  output logic                 frame_err,
  output logic [2:0]           point_rgb
);

  localparam int CNT_W = $clog2(WORD_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);
  // Cycles for reset-loaded synchronizer values to flush out of the pipeline.
  localparam int SET_W = $clog2(SYNC_STAGES + 3);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SYNC_STAGES + 2);

  logic mosi_s, sclk_s, csn_s, latchn_s;
  logic sclk_d, csn_d, latchn_d;
  logic sclk_rise, csn_fall, csn_rise, latch_fall, mosi_q, csn_q;
  state_t state, state_nxt;
  logic do_shift, do_clear, do_commit, do_err;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] in_a, in_b, in_a_nxt, in_b_nxt;
  logic [2:0] in_ctrl_a, in_ctrl_b, in_ctrl_a_nxt, in_ctrl_b_nxt;

  laser_dac_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b0))
    u_sync_mosi   (.clk(clk), .reset(reset), .d(dac_mosi),   .q(mosi_s));
  laser_dac_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b0))
    u_sync_sclk   (.clk(clk), .reset(reset), .d(dac_sclk),   .q(sclk_s));
  laser_dac_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1))
    u_sync_csn    (.clk(clk), .reset(reset), .d(dac_csn),    .q(csn_s));
  laser_dac_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RESET_VAL(1'b1))
    u_sync_latchn (.clk(clk), .reset(reset), .d(dac_latchn), .q(latchn_s));

  // Delay the synced lines one clk and register the edge events they reveal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d     <= 1'b0;
      csn_d      <= 1'b1;
      latchn_d   <= 1'b1;
      sclk_rise  <= 1'b0;
      csn_fall   <= 1'b0;
      csn_rise   <= 1'b0;
      latch_fall <= 1'b0;
      mosi_q     <= 1'b0;
      csn_q      <= 1'b1;
    end else begin
      sclk_d     <= sclk_s;
      csn_d      <= csn_s;
      latchn_d   <= latchn_s;
      sclk_rise  <= sclk_s & ~sclk_d;
      csn_fall   <= csn_d & ~csn_s;
      csn_rise   <= ~csn_d & csn_s;
      latch_fall <= latchn_d & ~latchn_s;
      mosi_q     <= mosi_s;   // aligned with sclk_rise
      csn_q      <= csn_s;    // csn level aligned with the events
    end
  end

  // State register plus the post-reset settle counter used by RESYNC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESYNC;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RESYNC && settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Next-state and frame actions; csn events take priority over sclk.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt = state;
    do_shift  = 1'b0;
    do_clear  = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    unique case (state)
      ST_RESYNC: if (settle_cnt == SETTLE_MAX && csn_q) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (csn_fall) begin
          state_nxt = ST_SHIFT;
          do_clear  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (csn_rise) begin
          state_nxt = ST_IDLE;
          if (bit_cnt == CNT_FULL) do_commit = 1'b1;
          else                     do_err    = 1'b1;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end
      end
      default: state_nxt = ST_RESYNC;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (do_clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      shreg <= {shreg[WORD_BITS-2:0], mosi_q};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Post-commit input register values, forwarded to a same-cycle latch.
  always_comb begin
    in_a_nxt      = in_a;
    in_b_nxt      = in_b;
    in_ctrl_a_nxt = in_ctrl_a;
    in_ctrl_b_nxt = in_ctrl_b;
    if (do_commit) begin
      if (shreg[CMD_AB_BIT]) begin
        in_b_nxt      = shreg[DATA_BITS-1:0];
        in_ctrl_b_nxt = {shreg[CMD_BUF_BIT], shreg[CMD_GA_BIT], shreg[CMD_SHDN_BIT]};
      end else begin
        in_a_nxt      = shreg[DATA_BITS-1:0];
        in_ctrl_a_nxt = {shreg[CMD_BUF_BIT], shreg[CMD_GA_BIT], shreg[CMD_SHDN_BIT]};
      end
    end
  end

  // Input and output registers, strobe and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these registers drive the DAC directly, so each one gets a
      // known safe value (code 0, shut down) rather than power-up garbage.
      in_a         <= '0;
      in_b         <= '0;
      in_ctrl_a    <= CTRL_RESET;
      in_ctrl_b    <= CTRL_RESET;
      dac_a        <= '0;
      dac_b        <= '0;
      ctrl_a       <= CTRL_RESET;
      ctrl_b       <= CTRL_RESET;
      point_strobe <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      in_a         <= in_a_nxt;
      in_b         <= in_b_nxt;
      in_ctrl_a    <= in_ctrl_a_nxt;
      in_ctrl_b    <= in_ctrl_b_nxt;
      point_strobe <= latch_fall;
      frame_err    <= do_err;
      if (latch_fall) begin
        dac_a  <= in_a_nxt;
        dac_b  <= in_b_nxt;
        ctrl_a <= in_ctrl_a_nxt;
        ctrl_b <= in_ctrl_b_nxt;
      end
    end
  end

`ifdef LASER_DAC_RX_RGB_EN
  logic [2:0] rgb_s;

  laser_dac_rx_sync #(.STAGES(2), .WIDTH(3), .RESET_VAL(3'b000))
    u_sync_rgb (.clk(clk), .reset(reset), .d(laser_rgb), .q(rgb_s));

  // Capture the laser colour on every latch, aligned with point_strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           point_rgb <= 3'b000;
    else if (latch_fall) point_rgb <= rgb_s;
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^laser_rgb;
  assign point_rgb  = 3'b000;
`endif

endmodule

// File: tb/tb_laser_dac_spi_rx.sv
// Self-checking bench for laser_dac_spi_rx: directed link scenarios plus
// randomized frames compared against a word-level reference model.
module tb_laser_dac_spi_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_mosi, dac_sclk, dac_csn, dac_latchn;
  logic [2:0]  laser_rgb;
  logic [11:0] dac_a, dac_b;
  logic [2:0]  ctrl_a, ctrl_b, point_rgb;
  logic        point_strobe, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int strobe_seen = 0;

  // Reference model: input registers and output registers at word level.
  logic [11:0] m_in_a, m_in_b, m_out_a, m_out_b;
  logic [2:0]  m_ci_a, m_ci_b, m_co_a, m_co_b, m_rgb;

  always #5 clk = ~clk;

  laser_dac_spi_rx #(.WORD_BITS(16), .DATA_BITS(12), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .dac_mosi(dac_mosi), .dac_sclk(dac_sclk),
    .dac_csn(dac_csn), .dac_latchn(dac_latchn), .laser_rgb(laser_rgb),
    .dac_a(dac_a), .dac_b(dac_b), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
    .point_strobe(point_strobe), .frame_err(frame_err), .point_rgb(point_rgb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count pulses on the two event outputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err)    err_seen++;
      if (point_strobe) strobe_seen++;
    end
  end

  function automatic void model_reset();
    m_in_a = '0; m_in_b = '0; m_out_a = '0; m_out_b = '0;
    m_ci_a = 3'b010; m_ci_b = 3'b010; m_co_a = 3'b010; m_co_b = 3'b010;
    m_rgb  = 3'b000;
  endfunction

  // Apply a frame of n bits (the low n bits of w); returns 1 if it is malformed.
  function automatic bit model_frame(input logic [31:0] w, input int n);
    if (n != 16) return 1'b1;
    if (w[15]) begin m_in_b = w[11:0]; m_ci_b = w[14:12]; end
    else       begin m_in_a = w[11:0]; m_ci_a = w[14:12]; end
    return 1'b0;
  endfunction

  function automatic void model_latch();
    m_out_a = m_in_a; m_out_b = m_in_b; m_co_a = m_ci_a; m_co_b = m_ci_b;
`ifdef LASER_DAC_RX_RGB_EN
    m_rgb = laser_rgb;
`else
    m_rgb = 3'b000;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".dac_a"},     dac_a,     m_out_a);
    check({tag, ".dac_b"},     dac_b,     m_out_b);
    check({tag, ".ctrl_a"},    ctrl_a,    m_co_a);
    check({tag, ".ctrl_b"},    ctrl_b,    m_co_b);
    check({tag, ".point_rgb"}, point_rgb, m_rgb);
  endtask

  task automatic sclk_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dac_mosi = bits[i];
      repeat (3) @(negedge clk);
      dac_sclk = 1'b1;
      repeat (3) @(negedge clk);
      dac_sclk = 1'b0;
    end
  endtask

  // latchn has just been driven low at this negedge: wait for the strobe.
  task automatic finish_latch(input string tag);
    int k;
    int s0;
    k  = 0;
    s0 = strobe_seen;
    model_latch();
    while (!point_strobe && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, k, SYNC + 2);
    check({tag, ".strobe_dac_a"}, dac_a, m_out_a);
    check({tag, ".strobe_rgb"}, point_rgb, m_rgb);
    repeat (3) @(negedge clk);
    dac_latchn = 1'b1;
    repeat (6) @(negedge clk);
    check({tag, ".strobes"}, strobe_seen - s0, 1);
    check_outputs(tag);
  endtask

  task automatic pulse_latch(input string tag);
    dac_latchn = 1'b0;
    finish_latch(tag);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] bits, input int n,
                            input bit with_latch);
    int e0;
    bit exp_err;
    e0 = err_seen;
    dac_csn = 1'b0;
    repeat (4) @(negedge clk);
    sclk_bits(bits, n);
    repeat (3) @(negedge clk);
    exp_err = model_frame(bits, n);
    dac_csn = 1'b1;
    if (with_latch) begin
      dac_latchn = 1'b0;
      finish_latch(tag);
    end else begin
      repeat (8) @(negedge clk);
    end
    check({tag, ".frame_err"}, err_seen - e0, {31'd0, exp_err});
  endtask

  task automatic hold_reset(input string tag);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    check_outputs(tag);
    check({tag, ".strobe"}, point_strobe, 1'b0);
    check({tag, ".err"}, frame_err, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int e0;
    logic [31:0] w;
    int n;
    reset = 1'b1; dac_mosi = 1'b0; dac_sclk = 1'b0; dac_csn = 1'b1;
    dac_latchn = 1'b1; laser_rgb = 3'b000;
    hold_reset("reset");
    repeat (10) @(negedge clk);

    // Basic A and B words, then latch.
    send_frame("t1a", 32'h0ABC, 16, 1'b0);
    send_frame("t1b", 32'h8123, 16, 1'b0);
    pulse_latch("t1");

    // Short and long frames are rejected.
    send_frame("t2short", 32'h0555, 15, 1'b0);
    send_frame("t2long",  32'h1_8777, 17, 1'b0);
    pulse_latch("t2");

    // Reset in the middle of a frame, released with csn still low.
    e0 = err_seen;
    dac_csn = 1'b0;
    repeat (4) @(negedge clk);
    sclk_bits(32'h0F, 8);
    hold_reset("t3reset");
    sclk_bits(32'hEE, 8);
    repeat (3) @(negedge clk);
    dac_csn = 1'b1;
    repeat (10) @(negedge clk);
    check("t3.no_err", err_seen - e0, 0);
    pulse_latch("t3nocommit");
    send_frame("t3next", 32'h0246, 16, 1'b0);
    pulse_latch("t3commit");

    // Commit and latch on the same synced clk: latch sees the new word.
    send_frame("t4", 32'h0FFF, 16, 1'b1);

    // Stray sclk edges while deselected, then a valid B word.
    repeat (5) begin
      dac_sclk = 1'b1; repeat (3) @(negedge clk);
      dac_sclk = 1'b0; repeat (3) @(negedge clk);
    end
    send_frame("t5", 32'h9555, 16, 1'b0);
    pulse_latch("t5");

    // Colour capture on latch (zero in the default build).
    laser_rgb = 3'b101;
    repeat (4) @(negedge clk);
    pulse_latch("t6");

    // Randomized frames of mostly-correct length with occasional latches.
    for (int it = 0; it < 24; it++) begin
      w = $urandom;
      n = ($urandom_range(0, 4) < 3) ? 16 : int'($urandom_range(0, 20));
      laser_rgb = 3'($urandom);
      send_frame("rand", w, n, 1'b0);
      if ($urandom_range(0, 2) == 0) pulse_latch("rand_latch");
    end
    pulse_latch("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
